// File: rtl/lsu_ecc_scrub_if.sv
// Signal bundle between the LSU DCCM ECC scrubber and the rest of the LSU.
// The master side drives DCCM read results and arbiter/CSR controls.
// The slave side (the scrubber) returns corrected data, flags and the writeback head.
interface lsu_ecc_scrub_if #(
   parameter int NUM_BANKS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
);
   logic                            ecc_disable;
   logic [NUM_BANKS-1:0]            rd_valid;
   logic [NUM_BANKS*ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_BANKS*32-1:0]         rd_data;
   logic [NUM_BANKS*7-1:0]          rd_ecc;
   logic [NUM_BANKS*32-1:0]         corr_data;
   logic [NUM_BANKS-1:0]            single_err;
   logic [NUM_BANKS-1:0]            double_err;
   logic                            wb_valid;
   logic                            wb_ready;
   logic [ADDR_WIDTH-1:0]           wb_addr;
   logic [31:0]                     wb_data;
   logic [6:0]                      wb_ecc;
   logic                            wb_drop;
   logic [CNT_WIDTH-1:0]            sb_err_cnt;
   logic                            db_log_valid;
   logic [ADDR_WIDTH-1:0]           db_log_addr;
   logic                            db_log_clr;

   modport master (
      output ecc_disable, rd_valid, rd_addr, rd_data, rd_ecc, wb_ready, db_log_clr,
      input  corr_data, single_err, double_err, wb_valid, wb_addr, wb_data, wb_ecc,
             wb_drop, sb_err_cnt, db_log_valid, db_log_addr
   );

   modport slave (
      input  ecc_disable, rd_valid, rd_addr, rd_data, rd_ecc, wb_ready, db_log_clr,
      output corr_data, single_err, double_err, wb_valid, wb_addr, wb_data, wb_ecc,
             wb_drop, sb_err_cnt, db_log_valid, db_log_addr
   );
endinterface

// File: rtl/lsu_ecc_scrub.sv
// Multi-bank DCCM SECDED check-and-repair for the LSU.
// Each bank is decoded in parallel and registered; single-bit corrections are
// queued for scrub writeback, single errors are counted (saturating) and the
// first double error address is held in a sticky log.
// Code: 39-bit Hamming (positions 1..38, parity at powers of two) plus an
// overall parity bit in ecc[6].
module lsu_ecc_scrub #(
   parameter int NUM_BANKS  = 2,
   parameter int ADDR_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic           clk,
   input  logic           rst_l,
   lsu_ecc_scrub_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam int ENT_W = ADDR_WIDTH + 32;
   localparam int SUM_W = CNT_WIDTH + 4;

   // Hamming check bits: data bits fill non-power-of-two positions from 3 upward.
   function automatic logic [6:0] f_ecc_encode(input logic [31:0] d);
      logic [38:1] cw;
      logic [6:0]  e;
      int          di;
      cw = '0;
      di = 0;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p] = d[di];
            di++;
         end
      end
      e = '0;
      for (int k = 0; k < 6; k++) begin
         for (int p = 1; p <= 38; p++) begin
            if (p[k]) e[k] = e[k] ^ cw[p];
         end
      end
      e[6] = (^d) ^ (^e[5:0]);
      return e;
   endfunction

   // Returns {single, double, corrected_data}; a disabled decode passes data through.
   function automatic logic [33:0] f_ecc_decode(input logic en, input logic [31:0] d,
                                                input logic [6:0] ecc);
      logic [6:0]  calc;
      logic [5:0]  synd;
      logic        ovr;
      logic        sgl;
      logic        dbl;
      logic [31:0] dout;
      int          di;
      calc = f_ecc_encode(d);
      synd = calc[5:0] ^ ecc[5:0];
      ovr  = ^{d, ecc};
      sgl  = en & ovr;
      dbl  = en & (synd != '0) & ~ovr;
      dout = d;
      di   = 0;
      for (int p = 1; p <= 38; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (sgl && (int'(synd) == p)) dout[di] = ~d[di];
            di++;
         end
      end
      return {sgl, dbl, dout};
   endfunction

   logic [NUM_BANKS*32-1:0]         w_dec_data;
   logic [NUM_BANKS-1:0]            w_dec_sgl;
   logic [NUM_BANKS-1:0]            w_dec_dbl;

   logic [NUM_BANKS*32-1:0]         r_corr;
   logic [NUM_BANKS*ADDR_WIDTH-1:0] r_addr;
   logic [NUM_BANKS-1:0]            r_sgl;
   logic [NUM_BANKS-1:0]            r_dbl;

   logic [ENT_W-1:0]                r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]                r_wr_ptr;
   logic [PTR_W-1:0]                r_rd_ptr;
   logic [OCC_W-1:0]                r_count;
   logic                            r_drop;
   logic [CNT_WIDTH-1:0]            r_cnt;
   logic                            r_log_valid;
   logic [ADDR_WIDTH-1:0]           r_log_addr;

   logic [OCC_W-1:0]                w_free;
   logic [OCC_W-1:0]                w_num_push;
   logic [NUM_BANKS-1:0]            w_push_en;
   logic [NUM_BANKS*PTR_W-1:0]      w_push_slot;
   logic                            w_drop_now;
   logic                            w_pop;
   logic                            w_wb_valid;
   logic [ENT_W-1:0]                w_head;
   logic [31:0]                     w_wb_data;
   logic [SUM_W-1:0]                w_sgl_num;
   logic [SUM_W-1:0]                w_cnt_sum;
   logic [ADDR_WIDTH-1:0]           w_dbl_addr;

   for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [33:0] w_dec;
      assign w_dec = f_ecc_decode(bus.rd_valid[gi] & ~bus.ecc_disable,
                                  bus.rd_data[gi*32 +: 32], bus.rd_ecc[gi*7 +: 7]);
      assign w_dec_data[gi*32 +: 32] = w_dec[31:0];
      assign w_dec_dbl[gi]           = w_dec[32];
      assign w_dec_sgl[gi]           = w_dec[33];
   end

   // Output stage: corrected data, flags and the matching address for the push.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_corr <= '0;
         r_addr <= '0;
         r_sgl  <= '0;
         r_dbl  <= '0;
      end else begin
         r_corr <= w_dec_data;
         r_addr <= bus.rd_addr;
         r_sgl  <= w_dec_sgl;
         r_dbl  <= w_dec_dbl;
      end
   end

   // Single-error popcount and lowest-bank double-error address.
   always_comb begin
      w_sgl_num  = '0;
      w_dbl_addr = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         w_sgl_num = w_sgl_num + SUM_W'(w_dec_sgl[b]);
      end
      for (int b = NUM_BANKS - 1; b >= 0; b--) begin
         if (w_dec_dbl[b]) w_dbl_addr = bus.rd_addr[b*ADDR_WIDTH +: ADDR_WIDTH];
      end
      w_cnt_sum = SUM_W'(r_cnt) + w_sgl_num;
   end

   // Push planner: slots are granted in bank order against start-of-cycle space.
   always_comb begin
      w_free      = OCC_W'(FIFO_DEPTH) - r_count;
      w_num_push  = '0;
      w_push_en   = '0;
      w_push_slot = '0;
      w_drop_now  = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (r_sgl[b]) begin
            if (w_num_push < w_free) begin
               w_push_en[b]                = 1'b1;
               w_push_slot[b*PTR_W +: PTR_W] = r_wr_ptr + w_num_push[PTR_W-1:0];
               w_num_push                  = w_num_push + OCC_W'(1);
            end else begin
               w_drop_now = 1'b1;
            end
         end
      end
   end

   assign w_wb_valid = (r_count != '0);
   assign w_pop      = w_wb_valid & bus.wb_ready;
   assign w_head     = r_mem[r_rd_ptr];
   assign w_wb_data  = w_wb_valid ? w_head[31:0] : '0;

   // FIFO pointers and occupancy; push and pop in the same cycle both apply.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + w_num_push[PTR_W-1:0];
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count  <= r_count + w_num_push - OCC_W'(w_pop);
      end
   end

   // FIFO storage; validity is tracked by the pointers so no reset is needed.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (w_push_en[b]) begin
            r_mem[w_push_slot[b*PTR_W +: PTR_W]] <= {r_addr[b*ADDR_WIDTH +: ADDR_WIDTH],
                                                     r_corr[b*32 +: 32]};
         end
      end
   end

   // Error bookkeeping: saturating counter, sticky drop flag and double-error log.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_cnt       <= '0;
         r_drop      <= 1'b0;
         r_log_valid <= 1'b0;
         r_log_addr  <= '0;
      end else begin
         if (w_cnt_sum[SUM_W-1:CNT_WIDTH] != '0) r_cnt <= '1;
         else                                    r_cnt <= w_cnt_sum[CNT_WIDTH-1:0];
         // A loss in the clearing cycle is still reported.
         if (w_drop_now)          r_drop <= 1'b1;
         else if (bus.db_log_clr) r_drop <= 1'b0;
         // A new double error in the clearing cycle re-arms the log with its address.
         if ((w_dec_dbl != '0) && (!r_log_valid || bus.db_log_clr)) begin
            r_log_valid <= 1'b1;
            r_log_addr  <= w_dbl_addr;
         end else if (bus.db_log_clr) begin
            r_log_valid <= 1'b0;
         end
      end
   end

   assign bus.corr_data    = r_corr;
   assign bus.single_err   = r_sgl;
   assign bus.double_err   = r_dbl;
   assign bus.wb_valid     = w_wb_valid;
   assign bus.wb_addr      = w_wb_valid ? w_head[ENT_W-1:32] : '0;
   assign bus.wb_data      = w_wb_data;
   assign bus.wb_ecc       = f_ecc_encode(w_wb_data);
   assign bus.wb_drop      = r_drop;
   assign bus.sb_err_cnt   = r_cnt;
   assign bus.db_log_valid = r_log_valid;
   assign bus.db_log_addr  = r_log_addr;
endmodule

// File: doc/lsu_ecc_scrub.md
Name: lsu_ecc_scrub

Overview:
Multi-bank DCCM ECC check-and-repair block for the LSU.
- Decodes SECDED on NUM_BANKS parallel DCCM read ports and registers the corrected data and error flags.
- Queues each single-bit-corrected word into a writeback FIFO so the DCCM arbiter can scrub it back to memory.
- Keeps a saturating single-error counter and a sticky double-error address log for the trap/CSR logic.

Parameters:
NUM_BANKS, 2, number of independent DCCM read ports checked in parallel (1..8)
ADDR_WIDTH, 16, DCCM word-address width per bank
FIFO_DEPTH, 4, writeback FIFO entries (power of 2, >=2)
CNT_WIDTH, 16, single-error counter width

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
ecc_disable  in  1  suppresses all detection, correction, queueing and counting
rd_valid  in  NUM_BANKS  per-bank read data valid this cycle
rd_addr  in  NUM_BANKS*ADDR_WIDTH  per-bank word address, bank b at [b*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  in  NUM_BANKS*32  raw data, bank b at [b*32 +: 32]
rd_ecc  in  NUM_BANKS*7  stored ECC, bank b at [b*7 +: 7]
corr_data  out  NUM_BANKS*32  registered corrected data
single_err  out  NUM_BANKS  registered per-bank single-error pulse
double_err  out  NUM_BANKS  registered per-bank double-error pulse
wb_valid  out  1  FIFO head valid
wb_ready  in  1  arbiter accepts head
wb_addr  out  ADDR_WIDTH  head address
wb_data  out  32  head corrected data
wb_ecc  out  7  ECC re-encoded from wb_data
wb_drop  out  1  sticky: a correction was lost because the FIFO was full
sb_err_cnt  out  CNT_WIDTH  saturating count of single errors
db_log_valid  out  1  double-error log holds an entry
db_log_addr  out  ADDR_WIDTH  address of the first logged double error
db_log_clr  in  1  clears the log and wb_drop

Behaviour:
- Decode uses the existing rvecc_decode per bank (sed_ded=0). Enable for bank b = rd_valid[b] & ~ecc_disable.
- Outputs are registered with 1-cycle latency: the cycle-N inputs appear on corr_data, single_err and double_err in cycle N+1.
- When the decoder enable is 0, the registered corr_data equals rd_data and both error flags are 0.
- Reset values: corr_data 0, single_err 0, double_err 0, wb_valid 0, wb_addr 0, wb_data 0, wb_drop 0, sb_err_cnt 0, db_log_valid 0, db_log_addr 0. FIFO pointers are reset to empty.
- wb_ecc is combinational rvecc_encode of wb_data; it is therefore the encoding of 0 at reset.
- Enqueue happens in cycle N+1 from the registered flags. Every bank with single_err=1 pushes {rd_addr, corr_data} in ascending bank order.
- A push needs a free slot. Free slots = FIFO_DEPTH - count, measured at the start of the cycle; a same-cycle pop does not create space.
- Pushes beyond the free slots are discarded, and wb_drop is set (sticky). Double-error words are never queued.
- Dequeue: the head retires on wb_valid & wb_ready. Head outputs are stable while wb_valid & ~wb_ready.
- Push and pop in the same cycle are both honoured. Pointers wrap modulo FIFO_DEPTH, and the count stays exact.
- sb_err_cnt adds popcount(single_err) each cycle and saturates at all ones; it never wraps. Only reset clears it.
- Double-error log: when db_log_valid=0 and any double_err is 1, capture the address of the lowest-index erroring bank and set db_log_valid.
- While db_log_valid=1, further double errors are ignored.
- db_log_clr clears db_log_valid and wb_drop. If a double error arrives in the same cycle as db_log_clr, it is captured (capture wins) and db_log_valid stays 1.
- Setting ecc_disable mid-stream affects new reads only. Entries already in the FIFO still drain.
- Reset asserted mid-operation empties the FIFO immediately and asynchronously, and returns every output to its reset value.

Test Plan:
- Bank0 valid, data 0x12345678 with a correct ECC but data bit 5 flipped -> in cycle N+1: corr_data[31:0]=0x12345678, single_err=01, sb_err_cnt=1. One cycle later: wb_valid=1, wb_addr=rd_addr[0], wb_data=0x12345678, wb_ecc=encode(0x12345678).
- Both banks single-error in the same cycle, addresses 0x10 and 0x20, wb_ready=0 -> FIFO count 2, head address 0x10; after one wb_ready pulse, head address 0x20; sb_err_cnt=2.
- FIFO_DEPTH=4, wb_ready=0, 5 single errors over 5 cycles -> 4 entries held, wb_drop=1, sb_err_cnt=5. Then assert db_log_clr -> wb_drop=0 and the entries are unchanged.
- Double error (2 bits flipped) on bank1 at address 0x33 -> double_err=10, db_log_valid=1, db_log_addr=0x33, nothing queued. A later double error at address 0x44 leaves db_log_addr=0x33. db_log_clr together with a new double error at 0x55 -> db_log_addr=0x55.
- ecc_disable=1 with a 1-bit corrupted word -> corr_data equals the raw (uncorrected) data, no flags, no push, counter unchanged.
- CNT_WIDTH=2: 5 single errors -> sb_err_cnt holds at 3. Assert rst_l=0 mid-drain -> wb_valid, sb_err_cnt and db_log_valid all 0 asynchronously.
